// File: rtl/rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit_ctrl
//  Description : In-order ROB commit scheduler. Retires the longest legal
//                prefix of the head slots each cycle, serialises stores via
//                an LSU req/ack handshake, handles branch-delay-slot flushes,
//                drives the register-file write ports and counts retirements.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_commit_ctrl #(
  parameter  int DEPTH        = 16,
  parameter  int EXT_COUNT    = 4,
  parameter  int RF_PORTS     = 2,
  localparam int DEPTHLOG2    = $clog2(DEPTH),
  localparam int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [DEPTHLOG2-1:0]    head_idx,
  input  logic                    slot_valid      [EXT_COUNT],
  input  logic                    slot_dest_valid [EXT_COUNT],
  input  logic [4:0]              slot_dest_reg   [EXT_COUNT],
  input  logic [31:0]             slot_result     [EXT_COUNT],
  input  logic                    slot_is_store   [EXT_COUNT],
  input  logic                    slot_mispredict [EXT_COUNT],
  output logic                    consume,
  output logic [EXTCOUNTLOG2-1:0] consume_count,
  output logic                    flush,
  output logic [DEPTHLOG2-1:0]    flush_idx,
  output logic                    rf_we    [RF_PORTS],
  output logic [4:0]              rf_waddr [RF_PORTS],
  output logic [31:0]             rf_wdata [RF_PORTS],
  output logic                    store_req,
  output logic [DEPTHLOG2-1:0]    store_slot,
  input  logic                    store_ack,
  output logic [31:0]             retired
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    ST_WAIT  = 2'd1,
    BDS_WAIT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DEPTHLOG2-1:0] r_flush_idx;
  logic [DEPTHLOG2-1:0] r_store_slot;
  logic [31:0]          r_retired;

  int                   w_scan_len;
  int                   w_scan_writes;
  logic                 w_scan_stop;
  int                   w_mp_idx;
  logic                 w_mp_found;
  logic [DEPTHLOG2-1:0] w_mp_rob_idx;
  int                   w_n;
  int                   w_port;

  // Longest legal prefix ignoring stores-at-head and mispredicts: stops at a
  // hole, at a store behind slot 0, or when the RF write ports run out.
  // Writes to GPR 0 are suppressed later but still occupy a port here.
  always_comb begin
    w_scan_len    = 0;
    w_scan_writes = 0;
    w_scan_stop   = 1'b0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (!w_scan_stop) begin
        if (!slot_valid[i] || (slot_is_store[i] && i > 0) ||
            (w_scan_writes + (slot_dest_valid[i] ? 1 : 0) > RF_PORTS)) begin
          w_scan_stop = 1'b1;
        end else begin
          w_scan_writes = w_scan_writes + (slot_dest_valid[i] ? 1 : 0);
          w_scan_len    = i + 1;
        end
      end
    end
  end

  // First mispredicted branch inside the legal prefix.
  always_comb begin
    w_mp_found = 1'b0;
    w_mp_idx   = 0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (!w_mp_found && i < w_scan_len && slot_mispredict[i]) begin
        w_mp_found = 1'b1;
        w_mp_idx   = i;
      end
    end
    w_mp_rob_idx = head_idx + DEPTHLOG2'(w_mp_idx);
  end

  // Next state, retire count, flush and store handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_n         = 0;
    flush       = 1'b0;
    flush_idx   = r_flush_idx;
    store_req   = 1'b0;
    store_slot  = r_store_slot;
    case (r_state)
      RUN: begin
        if (slot_valid[0] && slot_is_store[0]) begin
          store_req  = 1'b1;
          store_slot = head_idx;
          if (store_ack) begin
            w_n = 1;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else if (w_mp_found) begin
          // Delay slot is retirable now: retire branch + BDS and flush.
          if (w_mp_idx + 1 < w_scan_len) begin
            w_n       = w_mp_idx + 2;
            flush     = 1'b1;
            flush_idx = w_mp_rob_idx;
          end else begin
            w_n         = w_mp_idx + 1;
            w_state_nxt = BDS_WAIT;
          end
        end else begin
          w_n = w_scan_len;
        end
      end
      ST_WAIT: begin
        store_req = 1'b1;
        if (store_ack) begin
          w_n         = 1;
          w_state_nxt = RUN;
        end
      end
      BDS_WAIT: begin
        // Head stays put until the BDS retires, so a BDS store can present
        // head_idx directly each cycle without a separate held slot.
        if (slot_valid[0]) begin
          if (slot_is_store[0]) begin
            store_req  = 1'b1;
            store_slot = head_idx;
          end
          if (!slot_is_store[0] || store_ack) begin
            w_n         = 1;
            flush       = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      default: w_state_nxt = RUN;
    endcase
    consume       = (w_n > 0);
    consume_count = (w_n > 0) ? EXTCOUNTLOG2'(w_n - 1) : '0;
  end

  // Pack retiring GPR writes onto the RF ports in slot order.
  always_comb begin
    for (int k = 0; k < RF_PORTS; k++) begin
      rf_we[k]    = 1'b0;
      rf_waddr[k] = '0;
      rf_wdata[k] = '0;
    end
    w_port = 0;
    for (int j = 0; j < EXT_COUNT; j++) begin
      if (j < w_n && slot_dest_valid[j]) begin
        for (int k = 0; k < RF_PORTS; k++) begin
          if (k == w_port) begin
            rf_we[k]    = (slot_dest_reg[j] != 5'd0);
            rf_waddr[k] = slot_dest_reg[j];
            rf_wdata[k] = slot_result[j];
          end
        end
        w_port = w_port + 1;
      end
    end
  end

  // State, held indices and retired-instruction counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= RUN;
      r_flush_idx  <= '0;
      r_store_slot <= '0;
      r_retired    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_retired <= r_retired + 32'(w_n);
      if (r_state == RUN && w_state_nxt == ST_WAIT) begin
        r_store_slot <= head_idx;
      end
      if (r_state == RUN && w_state_nxt == BDS_WAIT) begin
        r_flush_idx <= w_mp_rob_idx;
      end
    end
  end

  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_commit_ctrl
//  Description : Self-checking bench for rob_commit_ctrl: directed vector
//                table, multi-cycle corner sequences and random stimulus
//                against a behavioural commit model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_commit_ctrl;
  localparam int EXT = 4;
  localparam int RFP = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  head_idx;
  logic        slot_valid      [EXT];
  logic        slot_dest_valid [EXT];
  logic [4:0]  slot_dest_reg   [EXT];
  logic [31:0] slot_result     [EXT];
  logic        slot_is_store   [EXT];
  logic        slot_mispredict [EXT];
  logic        consume;
  logic [1:0]  consume_count;
  logic        flush;
  logic [3:0]  flush_idx;
  logic        rf_we    [RFP];
  logic [4:0]  rf_waddr [RFP];
  logic [31:0] rf_wdata [RFP];
  logic        store_req;
  logic [3:0]  store_slot;
  logic        store_ack;
  logic [31:0] retired;

  always #5 clock = ~clock;

  rob_commit_ctrl #(.DEPTH(16), .EXT_COUNT(EXT), .RF_PORTS(RFP)) dut (
    .clock(clock), .reset_n(reset_n), .head_idx(head_idx),
    .slot_valid(slot_valid), .slot_dest_valid(slot_dest_valid),
    .slot_dest_reg(slot_dest_reg), .slot_result(slot_result),
    .slot_is_store(slot_is_store), .slot_mispredict(slot_mispredict),
    .consume(consume), .consume_count(consume_count), .flush(flush),
    .flush_idx(flush_idx), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .store_req(store_req), .store_slot(store_slot),
    .store_ack(store_ack), .retired(retired)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model status: what the commit unit is waiting for, if anything.
  logic        m_store_wait, m_bds_wait;
  logic [3:0]  m_held_flush, m_held_store;
  logic [31:0] m_retired;
  logic [3:0]  tb_head;
  // Model expectations for the current cycle and its successor status.
  int          e_n;
  logic        e_flush, e_req;
  logic [3:0]  e_fidx, e_sslot;
  logic        e_we    [RFP];
  logic [4:0]  e_waddr [RFP];
  logic [31:0] e_wdata [RFP];
  logic        nx_store_wait, nx_bds_wait;
  logic [3:0]  nx_held_flush, nx_held_store;

  typedef struct {
    string      name;
    logic [3:0] hd, v, dv, st, mp;
    logic [19:0] rg;
    logic       e_cons;
    logic [1:0] e_cc;
    logic       e_flush;
    logic [3:0] e_fidx;
    logic       e_req;
    logic [1:0] e_we;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] hd, input logic [3:0] v, input logic [3:0] dv,
                       input logic [3:0] st, input logic [3:0] mp, input logic [19:0] rg,
                       input logic ack);
    head_idx  = hd;
    store_ack = ack;
    for (int i = 0; i < EXT; i++) begin
      slot_valid[i]      = v[i];
      slot_dest_valid[i] = dv[i];
      slot_is_store[i]   = st[i];
      slot_mispredict[i] = mp[i];
      slot_dest_reg[i]   = rg[5*i +: 5];
      slot_result[i]     = $urandom;
    end
  endtask

  task automatic model_reset();
    m_store_wait = 1'b0; m_bds_wait = 1'b0;
    m_held_flush = '0;   m_held_store = '0;
    m_retired    = '0;   tb_head = '0;
  endtask

  // Commit rules evaluated directly: find what retires, then lay out RF writes.
  task automatic model_eval();
    int len, left, mp, k;
    e_n = 0; e_flush = 1'b0; e_fidx = '0; e_req = 1'b0; e_sslot = '0;
    nx_store_wait = m_store_wait; nx_bds_wait = m_bds_wait;
    nx_held_flush = m_held_flush; nx_held_store = m_held_store;
    if (m_store_wait) begin
      e_req = 1'b1; e_sslot = m_held_store;
      if (store_ack) begin e_n = 1; nx_store_wait = 1'b0; end
    end else if (m_bds_wait) begin
      if (slot_valid[0]) begin
        if (slot_is_store[0]) begin e_req = 1'b1; e_sslot = head_idx; end
        if (!slot_is_store[0] || store_ack) begin
          e_n = 1; e_flush = 1'b1; e_fidx = m_held_flush; nx_bds_wait = 1'b0;
        end
      end
    end else if (slot_valid[0] && slot_is_store[0]) begin
      e_req = 1'b1; e_sslot = head_idx;
      if (store_ack) e_n = 1;
      else begin nx_store_wait = 1'b1; nx_held_store = head_idx; end
    end else begin
      left = RFP; len = 0;
      while (len < EXT && slot_valid[len] && !(slot_is_store[len] && len > 0) &&
             left >= int'(slot_dest_valid[len])) begin
        left -= int'(slot_dest_valid[len]);
        len++;
      end
      mp = -1;
      for (int i = len - 1; i >= 0; i--) if (slot_mispredict[i]) mp = i;
      if (mp < 0) e_n = len;
      else if (mp + 1 < len) begin
        e_n = mp + 2; e_flush = 1'b1; e_fidx = head_idx + 4'(mp);
      end else begin
        e_n = mp + 1; nx_bds_wait = 1'b1; nx_held_flush = head_idx + 4'(mp);
      end
    end
    for (int p = 0; p < RFP; p++) begin e_we[p] = 1'b0; e_waddr[p] = '0; e_wdata[p] = '0; end
    k = 0;
    for (int j = 0; j < e_n; j++) begin
      if (slot_dest_valid[j]) begin
        if (k < RFP) begin
          e_we[k] = (slot_dest_reg[j] != 5'd0);
          e_waddr[k] = slot_dest_reg[j];
          e_wdata[k] = slot_result[j];
        end
        k++;
      end
    end
  endtask

  // Let inputs settle, then compare every combinational output to the model.
  task automatic settle();
    #1;
    model_eval();
    chk("consume", {31'd0, consume}, {31'd0, e_n > 0});
    if (e_n > 0) chk("consume_count", {30'd0, consume_count}, 32'(e_n - 1));
    chk("flush", {31'd0, flush}, {31'd0, e_flush});
    if (e_flush) chk("flush_idx", {28'd0, flush_idx}, {28'd0, e_fidx});
    chk("store_req", {31'd0, store_req}, {31'd0, e_req});
    if (e_req) chk("store_slot", {28'd0, store_slot}, {28'd0, e_sslot});
    for (int p = 0; p < RFP; p++) begin
      chk("rf_we", {31'd0, rf_we[p]}, {31'd0, e_we[p]});
      if (e_we[p]) begin
        chk("rf_waddr", {27'd0, rf_waddr[p]}, {27'd0, e_waddr[p]});
        chk("rf_wdata", rf_wdata[p], e_wdata[p]);
      end
    end
  endtask

  // Clock edge: advance model, check the counter, return at the next negedge.
  task automatic advance();
    @(posedge clock); #1;
    m_retired    = m_retired + 32'(e_n);
    tb_head      = tb_head + 4'(e_n);
    m_store_wait = nx_store_wait; m_bds_wait   = nx_bds_wait;
    m_held_flush = nx_held_flush; m_held_store = nx_held_store;
    chk("retired", retired, m_retired);
    @(negedge clock);
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] hd, v, dv, st, mp,
                              input logic [19:0] rg, input logic cons, input logic [1:0] cc,
                              input logic fl, input logic [3:0] fi, input logic rq,
                              input logic [1:0] we);
    vec_t r;
    r.name = nm; r.hd = hd; r.v = v; r.dv = dv; r.st = st; r.mp = mp; r.rg = rg;
    r.e_cons = cons; r.e_cc = cc; r.e_flush = fl; r.e_fidx = fi; r.e_req = rq; r.e_we = we;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles, early_cons;
    logic [3:0] hd;
    // rg packs dest regs {slot3,slot2,slot1,slot0}, 5 bits each.
    vecs[0] = mk("four_alu",  4'd0,  4'hF, 4'b0101, 4'b0, 4'b0,    {5'd0, 5'd9, 5'd0, 5'd3}, 1, 2'd3, 0, 4'd0,  0, 2'b11);
    vecs[1] = mk("rf_limit",  4'd4,  4'h7, 4'b0111, 4'b0, 4'b0,    {5'd0, 5'd3, 5'd2, 5'd1}, 1, 2'd1, 0, 4'd0,  0, 2'b11);
    vecs[2] = mk("mp_flush",  4'd14, 4'h7, 4'b0000, 4'b0, 4'b0010, 20'd0,                    1, 2'd2, 1, 4'd15, 0, 2'b00);
    vecs[3] = mk("empty",     4'd1,  4'h0, 4'b0000, 4'b0, 4'b0,    20'd0,                    0, 2'd0, 0, 4'd0,  0, 2'b00);
    vecs[4] = mk("gpr0",      4'd5,  4'hF, 4'b0111, 4'b0, 4'b0,    {5'd0, 5'd7, 5'd5, 5'd0}, 1, 2'd1, 0, 4'd0,  0, 2'b10);
    vecs[5] = mk("store_mid", 4'd8,  4'h3, 4'b0000, 4'b0010, 4'b0, 20'd0,                    1, 2'd0, 0, 4'd0,  0, 2'b00);
    vecs[6] = mk("hole",      4'd9,  4'hD, 4'b0000, 4'b0, 4'b0,    20'd0,                    1, 2'd0, 0, 4'd0,  0, 2'b00);

    // Reset state.
    drive(4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 20'd0, 1'b0);
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_consume", {31'd0, consume}, 32'd0);
    chk("rst_cc", {30'd0, consume_count}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_flush_idx", {28'd0, flush_idx}, 32'd0);
    chk("rst_store_req", {31'd0, store_req}, 32'd0);
    chk("rst_store_slot", {28'd0, store_slot}, 32'd0);
    chk("rst_rf_we0", {31'd0, rf_we[0]}, 32'd0);
    chk("rst_rf_we1", {31'd0, rf_we[1]}, 32'd0);
    chk("rst_rf_waddr0", {27'd0, rf_waddr[0]}, 32'd0);
    chk("rst_rf_wdata0", rf_wdata[0], 32'd0);
    chk("rst_retired", retired, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed single-cycle vectors from RUN.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].hd, vecs[i].v, vecs[i].dv, vecs[i].st, vecs[i].mp, vecs[i].rg, 1'b0);
      settle();
      chk({vecs[i].name, "_cons"}, {31'd0, consume}, {31'd0, vecs[i].e_cons});
      if (vecs[i].e_cons) chk({vecs[i].name, "_cc"}, {30'd0, consume_count}, {30'd0, vecs[i].e_cc});
      chk({vecs[i].name, "_flush"}, {31'd0, flush}, {31'd0, vecs[i].e_flush});
      if (vecs[i].e_flush) chk({vecs[i].name, "_fidx"}, {28'd0, flush_idx}, {28'd0, vecs[i].e_fidx});
      chk({vecs[i].name, "_req"}, {31'd0, store_req}, {31'd0, vecs[i].e_req});
      chk({vecs[i].name, "_we0"}, {31'd0, rf_we[0]}, {31'd0, vecs[i].e_we[0]});
      chk({vecs[i].name, "_we1"}, {31'd0, rf_we[1]}, {31'd0, vecs[i].e_we[1]});
      advance();
      if (i == 0) chk("four_alu_retired", retired, 32'd4);
    end

    // Store at head, ack three cycles later; store_slot must stay put even
    // if head_idx wiggles meanwhile.
    req_cycles = 0; early_cons = 0;
    for (int c = 0; c < 4; c++) begin
      hd = (c == 0) ? 4'd6 : 4'd9;
      drive(hd, 4'h1, 4'h0, 4'h1, 4'h0, 20'd0, (c == 3));
      settle();
      if (store_req) req_cycles++;
      if (c < 3 && consume) early_cons++;
      chk("st_wait_slot", {28'd0, store_slot}, 32'd6);
      if (c == 3) chk("st_ack_cc", {30'd0, consume_count}, 32'd0);
      advance();
    end
    chk("st_req_cycles", 32'(req_cycles), 32'd4);
    chk("st_early_consume", 32'(early_cons), 32'd0);

    // Mispredict in the last head slot, BDS arrives two cycles later.
    drive(4'd15, 4'hF, 4'h0, 4'h0, 4'b1000, 20'd0, 1'b0);
    settle();
    chk("bds_br_cc", {30'd0, consume_count}, 32'd3);
    chk("bds_br_noflush", {31'd0, flush}, 32'd0);
    advance();
    for (int c = 0; c < 2; c++) begin
      drive(4'd3, 4'h0, 4'h0, 4'h0, 4'h0, 20'd0, 1'b0);
      settle();
      chk("bds_idle_consume", {31'd0, consume}, 32'd0);
      advance();
    end
    drive(4'd3, 4'h1, 4'h1, 4'h0, 4'h0, {15'd0, 5'd12}, 1'b0);
    settle();
    chk("bds_cc", {30'd0, consume_count}, 32'd0);
    chk("bds_flush", {31'd0, flush}, 32'd1);
    chk("bds_fidx", {28'd0, flush_idx}, 32'd2);
    advance();

    // Mispredict whose delay slot is a store: handshake, then flush on ack.
    drive(4'd4, 4'h3, 4'h0, 4'b0010, 4'b0001, 20'd0, 1'b0);
    settle();
    chk("bdsst_br_cc", {30'd0, consume_count}, 32'd0);
    advance();
    drive(4'd5, 4'h1, 4'h0, 4'h1, 4'h0, 20'd0, 1'b0);
    settle();
    chk("bdsst_wait_flush", {31'd0, flush}, 32'd0);
    chk("bdsst_wait_req", {31'd0, store_req}, 32'd1);
    advance();
    drive(4'd5, 4'h1, 4'h0, 4'h1, 4'h0, 20'd0, 1'b1);
    settle();
    chk("bdsst_ack_flush", {31'd0, flush}, 32'd1);
    chk("bdsst_ack_fidx", {28'd0, flush_idx}, 32'd4);
    advance();

    // Asynchronous reset while waiting on a store ack.
    drive(4'd7, 4'h1, 4'h0, 4'h1, 4'h0, 20'd0, 1'b0);
    settle();
    advance();
    #2;
    reset_n = 1'b0;
    drive(4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 20'd0, 1'b0);
    #1;
    chk("arst_store_req", {31'd0, store_req}, 32'd0);
    chk("arst_retired", retired, 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    drive(4'd0, 4'h1, 4'h0, 4'h0, 4'h0, 20'd0, 1'b0);
    settle();
    chk("arst_run_consume", {31'd0, consume}, 32'd1);
    advance();

    // Random stimulus; a pending store keeps its entry at the head.
    for (int c = 0; c < 400; c++) begin
      logic [3:0]  v, dv, st, mp;
      logic [19:0] rg;
      for (int i = 0; i < EXT; i++) begin
        v[i]  = ($urandom_range(0, 9) < 8);
        st[i] = ($urandom_range(0, 4) == 0);
        dv[i] = st[i] ? 1'b0 : 1'($urandom_range(0, 1));
        mp[i] = st[i] ? 1'b0 : ($urandom_range(0, 5) == 0);
        rg[5*i +: 5] = 5'($urandom_range(0, 31));
      end
      if (m_store_wait) begin
        v[0] = 1'b1; st[0] = 1'b1; dv[0] = 1'b0; mp[0] = 1'b0;
      end
      drive(tb_head, v, dv, st, mp, rg, ($urandom_range(0, 2) == 0));
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- In-order commit scheduler for the reorder buffer.
- Each cycle it inspects the up-to-EXT_COUNT head slots presented by the ROB retrieve interface and picks the longest retirable prefix, bounded by register-file write ports.
- It serialises stores through a req/ack handshake with the LSU and drives the ROB consume and flush interfaces.
- It also owns the architectural register-file write ports and a retired-instruction counter.

Parameters:
- DEPTH, 16, ROB depth; DEPTHLOG2 = $clog2(DEPTH)
- EXT_COUNT, 4, head slots inspected per cycle; EXTCOUNTLOG2 = $clog2(EXT_COUNT)
- RF_PORTS, 2, register-file write ports (1..EXT_COUNT)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- head_idx  in  DEPTHLOG2  ROB index of head slot 0 (ROB ext_ptr)
- slot_valid[EXT_COUNT]  in  1  head slot i holds a completed result
- slot_dest_valid[EXT_COUNT]  in  1  slot i writes a GPR
- slot_dest_reg[EXT_COUNT]  in  5  destination GPR
- slot_result[EXT_COUNT]  in  32  result value
- slot_is_store[EXT_COUNT]  in  1  slot i is a store
- slot_mispredict[EXT_COUNT]  in  1  slot i is a mispredicted branch
- consume  out  1  ROB consume strobe
- consume_count  out  EXTCOUNTLOG2  slots retired minus one
- flush  out  1  ROB/front-end flush strobe
- flush_idx  out  DEPTHLOG2  ROB index of the mispredicted branch
- rf_we[RF_PORTS]  out  1  register-file write enable
- rf_waddr[RF_PORTS]  out  5  write address
- rf_wdata[RF_PORTS]  out  32  write data
- store_req  out  1  store commit request
- store_slot  out  DEPTHLOG2  ROB index of the store
- store_ack  in  1  LSU accepted the store
- retired  out  32  count of retired instructions

Behaviour:
- Reset: state=RUN. consume, flush, rf_we, store_req are 0; consume_count, flush_idx, store_slot, rf_waddr, rf_wdata are 0; retired=0.
- All outputs are combinational from state + inputs, except state, the held flush_idx/store_slot registers and retired.
- Zero-cycle decision: outputs are valid in the same cycle the slots are presented.
- States: RUN, ST_WAIT, BDS_WAIT.
- RUN scan, i = 0 upward; n = number retired. Stop before slot i if any of:
  - !slot_valid[i]
  - slot_is_store[i] && i>0
  - including slot i would need more than RF_PORTS writes
- RUN, store at slot 0:
  - Retire nothing; store_req=1, store_slot=head_idx.
  - If store_ack is 1 in the same cycle: retire slot 0 and stay in RUN.
  - Otherwise go to ST_WAIT.
- RUN, mispredict at slot i (i inside the prefix):
  - If i+1<EXT_COUNT and slot_valid[i+1] and slot i+1 passes the scan (BDS retires too): n=i+2, flush=1, flush_idx=head_idx+i.
  - Else: n=i+1, flush_idx register <= head_idx+i, go to BDS_WAIT; no flush this cycle.
- ST_WAIT: hold store_req=1 with a stable store_slot. On store_ack: consume=1, consume_count=0, retired+=1, go to RUN. Nothing else retires while waiting.
- BDS_WAIT: when slot_valid[0], retire slot 0 only and assert flush=1 with the held flush_idx, then go to RUN. A BDS store follows the store handshake first; flush is asserted in the ack cycle.
- Consume: consume=(n>0), consume_count=n-1.
- RF writes: retired slots with dest_valid fill rf ports in slot order; unused ports have rf_we=0.
- Do not write GPR 0: rf_we=0, but the slot still counts toward RF_PORTS.
- Counter: retired += n each cycle, wrapping at 2^32.
- Index arithmetic is modulo DEPTH, so wrap-around of head_idx+i is natural.
- Empty ROB (all slot_valid=0): no action.
- Async reset mid-operation (ST_WAIT/BDS_WAIT) returns to RUN; store_req drops immediately.

Test Plan:
- Four valid ALU slots, two with dest_valid, RF_PORTS=2 -> consume=1, consume_count=3, both rf_we=1 in slot order, retired=4.
- Slots 0-2 valid, all with dest_valid, RF_PORTS=2 -> consume_count=1, rf writes for slots 0,1; slot 2 retires next cycle.
- Store at slot 0, store_ack asserted 3 cycles later -> store_req high 4 cycles with stable store_slot; then consume_count=0; no consume earlier.
- head_idx=14, mispredict at slot 1, slot 2 valid -> consume_count=2, flush=1, flush_idx=15.
- head_idx=15, mispredict at slot 3 -> consume_count=3, state BDS_WAIT; BDS arrives 2 cycles later -> consume_count=0, flush=1, flush_idx=2.
- reset_n pulsed low during ST_WAIT -> store_req=0 asynchronously, retired=0, RUN afterwards.
